// File: rtl/pll_reconfig_pkg.sv
// pll_reconfig_pkg: shared codes, state enum, counter config struct and chain flattening
package pll_reconfig_pkg;
    localparam int SCAN_LEN = 72;
    localparam int CNT_W    = 8;
    localparam int CFG_W    = 18;
    localparam int NUM_CNT  = 4;
    localparam int IDX_W    = $clog2(SCAN_LEN);

    localparam logic [3:0] CT_N  = 4'b0000;
    localparam logic [3:0] CT_M  = 4'b0001;
    localparam logic [3:0] CT_C0 = 4'b0100;
    localparam logic [3:0] CT_C1 = 4'b0101;

    localparam logic [2:0] CP_HIGH   = 3'b000;
    localparam logic [2:0] CP_LOW    = 3'b001;
    localparam logic [2:0] CP_BYPASS = 3'b100;
    localparam logic [2:0] CP_ODD    = 3'b101;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_SHIFT, S_UPDATE, S_SETTLE} state_t;

    // Field order matches the per-counter scan order, so the packed struct is the chain segment.
    typedef struct packed {
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] low;
        logic             bypass;
        logic             odd;
    } counter_cfg_t;

    localparam counter_cfg_t CFG_RESET = '{high: 8'h01, low: 8'h01, bypass: 1'b0, odd: 1'b0};

    typedef counter_cfg_t [NUM_CNT-1:0] cfg_file_t;

    function automatic logic type_ok(input logic [3:0] t);
        return t inside {CT_N, CT_M, CT_C0, CT_C1};
    endfunction

    function automatic logic param_ok(input logic [2:0] p);
        return p inside {CP_HIGH, CP_LOW, CP_BYPASS, CP_ODD};
    endfunction

    // N, M, C0, C1 map to slots 0..3 through type bits [2] and [0].
    function automatic logic [1:0] cnt_index(input logic [3:0] t);
        return {t[2], t[0]};
    endfunction

    function automatic logic [SCAN_LEN-1:0] flatten_chain(input cfg_file_t f);
        flatten_chain = '0;
        for (int i = 0; i < NUM_CNT; i++)
            flatten_chain[SCAN_LEN-1-CFG_W*i -: CFG_W] = f[i];
    endfunction
endpackage

// File: rtl/pll_scan_shifter.sv
// pll_scan_shifter: shifts a loaded scan-chain snapshot out MSB first with scanclkena
module pll_scan_shifter
    import pll_reconfig_pkg::*;
(
    input  logic                clock_ctr,
    input  logic                sys_reset,
    input  logic                reset,
    input  logic                i_load,
    input  logic [SCAN_LEN-1:0] i_data,
    output logic                scandata,
    output logic                scanclkena,
    output logic                o_done
);
    logic [SCAN_LEN-1:0] r_sh;
    logic [IDX_W-1:0]    r_idx;
    logic                r_active;

    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset || reset) begin
            r_sh     <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_sh     <= i_data;
            r_idx    <= IDX_W'(SCAN_LEN - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_sh     <= r_sh << 1;
            r_idx    <= (r_idx == '0) ? r_idx : r_idx - 1'b1;
            r_active <= r_idx != '0;
        end
    end

    assign scanclkena = r_active;
    assign scandata   = r_active & r_sh[SCAN_LEN-1];
    assign o_done     = r_active & (r_idx == '0);
endmodule

// File: rtl/pll_reconfig_responder.sv
// pll_reconfig_responder: PLL reconfig command responder with shadow parameter file
// and scan-chain serialiser.
module pll_reconfig_responder
    import pll_reconfig_pkg::*;
#(
    parameter int WRITE_BUSY = 2,
    parameter int READ_BUSY  = 2,
    parameter int SETTLE     = 4
) (
    input  logic       clock_ctr,
    input  logic       sys_reset,
    input  logic       reset,
    input  logic [3:0] counter_type,
    input  logic [2:0] counter_param,
    input  logic [8:0] data_in,
    input  logic       write_param,
    input  logic       read_param,
    input  logic       reconfig,
    output logic       busy,
    output logic [8:0] data_out,
    output logic       scandata,
    output logic       scanclkena,
    output logic       configupdate
);
    state_t       r_state, w_next;
    logic [2:0]   r_dly;
    cfg_file_t    r_file;
    logic [8:0]   r_data_out;
    logic         w_idle, w_start_rc, w_start_wr, w_start_rd, w_addr_ok, w_scan_done;
    logic [1:0]   w_idx;
    counter_cfg_t w_sel;
    logic [8:0]   w_rd_val;
    logic         w_unused;

    assign w_unused   = data_in[8];
    assign w_idle     = r_state == S_IDLE;
    assign w_start_rc = w_idle & reconfig;
    assign w_start_wr = w_idle & ~reconfig & write_param;
    assign w_start_rd = w_idle & ~reconfig & ~write_param & read_param;
    assign w_addr_ok  = type_ok(counter_type) & param_ok(counter_param);
    assign w_idx      = cnt_index(counter_type);
    assign w_sel      = r_file[w_idx];
    assign w_rd_val   = !w_addr_ok                 ? 9'd0 :
                        counter_param == CP_HIGH   ? {1'b0, w_sel.high} :
                        counter_param == CP_LOW    ? {1'b0, w_sel.low} :
                        counter_param == CP_BYPASS ? {8'd0, w_sel.bypass} :
                                                     {8'd0, w_sel.odd};
    assign data_out   = r_data_out;

    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset)
            r_state <= S_IDLE;
        else if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:                  w_next = w_start_rc ? S_SHIFT : w_start_wr ? S_WR : w_start_rd ? S_RD : S_IDLE;
            S_WR, S_RD, S_SETTLE:    w_next = (r_dly == '0) ? S_IDLE : r_state;
            S_SHIFT:                 w_next = w_scan_done ? S_UPDATE : S_SHIFT;
            S_UPDATE:                w_next = S_SETTLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = r_state != S_IDLE;
        configupdate = r_state == S_UPDATE;
    end

    // r_dly holds the remaining extra cycles of WR/RD/SETTLE after the current one.
    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset || reset)
            r_dly <= '0;
        else if (w_start_wr)
            r_dly <= 3'(WRITE_BUSY - 1);
        else if (w_start_rd)
            r_dly <= 3'(READ_BUSY - 1);
        else if (r_state == S_UPDATE)
            r_dly <= 3'(SETTLE - 1);
        else if (r_dly != '0)
            r_dly <= r_dly - 1'b1;
    end

    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset || reset) begin
            r_file <= {NUM_CNT{CFG_RESET}};
        end else if (w_start_wr && w_addr_ok) begin
            if (counter_param == CP_HIGH)
                r_file[w_idx].high <= data_in[7:0];
            else if (counter_param == CP_LOW)
                r_file[w_idx].low <= data_in[7:0];
            else if (counter_param == CP_BYPASS)
                r_file[w_idx].bypass <= data_in[0];
            else
                r_file[w_idx].odd <= data_in[0];
        end
    end

    always_ff @(posedge clock_ctr or posedge sys_reset) begin
        if (sys_reset || reset)
            r_data_out <= '0;
        else if (w_start_rd)
            r_data_out <= w_rd_val;
    end

    pll_scan_shifter u_shifter (
        .clock_ctr  (clock_ctr),
        .sys_reset  (sys_reset),
        .reset      (reset),
        .i_load     (w_start_rc),
        .i_data     (flatten_chain(r_file)),
        .scandata   (scandata),
        .scanclkena (scanclkena),
        .o_done     (w_scan_done)
    );
endmodule

// File: tb/tb_pll_reconfig_responder.sv
// tb_pll_reconfig_responder: table vectors, directed corner sequences and random
// traffic checked against a field-level model of the parameter file.
module tb_pll_reconfig_responder;
    localparam int WB = 2;
    localparam int RB = 2;
    localparam int ST = 4;
    localparam int SL = 72;

    logic       clock_ctr = 1'b0;
    logic       sys_reset = 1'b1;
    logic       reset = 1'b0;
    logic [3:0] counter_type = '0;
    logic [2:0] counter_param = '0;
    logic [8:0] data_in = '0;
    logic       write_param = 1'b0;
    logic       read_param = 1'b0;
    logic       reconfig = 1'b0;
    logic       busy;
    logic [8:0] data_out;
    logic       scandata, scanclkena, configupdate;

    pll_reconfig_responder #(.WRITE_BUSY(WB), .READ_BUSY(RB), .SETTLE(ST)) dut (
        .clock_ctr     (clock_ctr),
        .sys_reset     (sys_reset),
        .reset         (reset),
        .counter_type  (counter_type),
        .counter_param (counter_param),
        .data_in       (data_in),
        .write_param   (write_param),
        .read_param    (read_param),
        .reconfig      (reconfig),
        .busy          (busy),
        .data_out      (data_out),
        .scandata      (scandata),
        .scanclkena    (scanclkena),
        .configupdate  (configupdate)
    );

    always #5 clock_ctr = ~clock_ctr;

    int checks = 0;
    int passes = 0;
    int m_hi[4], m_lo[4], m_byp[4], m_odd[4];

    typedef struct {
        bit         wr;
        logic [3:0] t;
        logic [2:0] p;
        logic [8:0] d;
        logic [8:0] exp;
    } vec_t;
    vec_t vt[11];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int m_index(input logic [3:0] t);
        return t == 4'h0 ? 0 : t == 4'h1 ? 1 : t == 4'h4 ? 2 : t == 4'h5 ? 3 : -1;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 4; k++) begin
            m_hi[k] = 1; m_lo[k] = 1; m_byp[k] = 0; m_odd[k] = 0;
        end
    endtask

    task automatic m_write(input logic [3:0] t, input logic [2:0] p, input logic [8:0] d);
        int k = m_index(t);
        if (k < 0) return;
        case (p)
            3'd0: m_hi[k] = int'(d[7:0]);
            3'd1: m_lo[k] = int'(d[7:0]);
            3'd4: m_byp[k] = int'(d[0]);
            3'd5: m_odd[k] = int'(d[0]);
            default: ;
        endcase
    endtask

    function automatic logic [8:0] m_read(input logic [3:0] t, input logic [2:0] p);
        int k = m_index(t);
        if (k < 0) return 9'd0;
        case (p)
            3'd0: return 9'(m_hi[k]);
            3'd1: return 9'(m_lo[k]);
            3'd4: return 9'(m_byp[k]);
            3'd5: return 9'(m_odd[k]);
            default: return 9'd0;
        endcase
    endfunction

    // Expected chain built bit by bit in transmit order, then packed MSB = first bit.
    function automatic logic [71:0] m_chain();
        bit q[$];
        logic [71:0] c;
        for (int k = 0; k < 4; k++) begin
            for (int b = 7; b >= 0; b--) q.push_back(bit'((m_hi[k] >> b) & 1));
            for (int b = 7; b >= 0; b--) q.push_back(bit'((m_lo[k] >> b) & 1));
            q.push_back(bit'(m_byp[k]));
            q.push_back(bit'(m_odd[k]));
        end
        for (int i = 0; i < SL; i++) c[SL-1-i] = q[i];
        return c;
    endfunction

    task automatic tick();
        @(posedge clock_ctr);
        #1;
    endtask

    task automatic issue(input bit wr, input bit rd, input bit rc,
                         input logic [3:0] t, input logic [2:0] p, input logic [8:0] d);
        counter_type = t; counter_param = p; data_in = d;
        write_param = wr; read_param = rd; reconfig = rc;
        tick();
        write_param = 0; read_param = 0; reconfig = 0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic do_write(input string tag, input logic [3:0] t, input logic [2:0] p, input logic [8:0] d);
        int n;
        issue(1, 0, 0, t, p, d);
        m_write(t, p, d);
        busy_len(n);
        check({tag, " wr busy"}, 72'(n), 72'(WB));
    endtask

    task automatic do_read(input string tag, input logic [3:0] t, input logic [2:0] p, input logic [8:0] exp);
        int n;
        issue(0, 1, 0, t, p, 9'h0);
        check({tag, " rd data"}, 72'(data_out), 72'(exp));
        busy_len(n);
        check({tag, " rd busy"}, 72'(n), 72'(RB));
        check({tag, " rd hold"}, 72'(data_out), 72'(exp));
    endtask

    task automatic do_reconfig(input string tag, input bit with_wr, input int wr_at,
                               input logic [3:0] t, input logic [2:0] p, input logic [8:0] d);
        logic [71:0] exp, got;
        int n_se, first_se, last_se, n_cu, cu_at, last_busy, stray;
        exp = m_chain();
        got = '0;
        n_se = 0; first_se = -1; last_se = -1; n_cu = 0; cu_at = -1; last_busy = -1; stray = 0;
        issue(with_wr, 0, 1, t, p, d);
        for (int c = 1; c <= 100; c++) begin
            if (scanclkena === 1'b1) begin
                n_se++;
                if (first_se < 0) first_se = c;
                last_se = c;
                if (c <= SL) got[SL-c] = scandata;
            end else if (scandata !== 1'b0) stray++;
            if (configupdate === 1'b1) begin n_cu++; cu_at = c; end
            if (busy === 1'b1) last_busy = c;
            if (c == wr_at) begin
                counter_type = t; counter_param = p; data_in = d; write_param = 1;
            end else write_param = 0;
            tick();
        end
        check({tag, " scanclkena count"}, 72'(n_se), 72'(SL));
        check({tag, " scanclkena first"}, 72'(first_se), 72'(1));
        check({tag, " scanclkena last"}, 72'(last_se), 72'(SL));
        check({tag, " chain"}, got, exp);
        check({tag, " scandata idle"}, 72'(stray), 72'(0));
        check({tag, " configupdate count"}, 72'(n_cu), 72'(1));
        check({tag, " configupdate cycle"}, 72'(cu_at), 72'(SL + 1));
        check({tag, " busy fall"}, 72'(last_busy + 1), 72'(SL + 2 + ST));
    endtask

    initial begin
        vt[0]  = '{0, 4'h1, 3'h0, 9'h000, 9'h001};
        vt[1]  = '{1, 4'h1, 3'h0, 9'h00A, 9'h000};
        vt[2]  = '{0, 4'h1, 3'h0, 9'h000, 9'h00A};
        vt[3]  = '{1, 4'h3, 3'h0, 9'h055, 9'h000};
        vt[4]  = '{0, 4'h3, 3'h0, 9'h000, 9'h000};
        vt[5]  = '{1, 4'h4, 3'h4, 9'h1FF, 9'h000};
        vt[6]  = '{0, 4'h4, 3'h4, 9'h000, 9'h001};
        vt[7]  = '{1, 4'h5, 3'h1, 9'h1C3, 9'h000};
        vt[8]  = '{0, 4'h5, 3'h1, 9'h000, 9'h0C3};
        vt[9]  = '{0, 4'h5, 3'h6, 9'h000, 9'h000};
        vt[10] = '{0, 4'h0, 3'h5, 9'h000, 9'h000};

        m_reset();
        #12;
        check("rst busy", 72'(busy), 72'(0));
        check("rst data_out", 72'(data_out), 72'(0));
        check("rst scanclkena", 72'(scanclkena), 72'(0));
        check("rst scandata", 72'(scandata), 72'(0));
        check("rst configupdate", 72'(configupdate), 72'(0));
        @(posedge clock_ctr);
        #1 sys_reset = 0;
        tick();

        do_reconfig("rc_after_reset", 0, -1, 4'h0, 3'h0, 9'h0);

        for (int i = 0; i < 11; i++) begin
            if (vt[i].wr) do_write($sformatf("vec%0d", i), vt[i].t, vt[i].p, vt[i].d);
            else do_read($sformatf("vec%0d", i), vt[i].t, vt[i].p, vt[i].exp);
        end

        do_reconfig("rc_vs_write", 1, -1, 4'h0, 3'h0, 9'h077);
        do_read("rc_vs_write N.high", 4'h0, 3'h0, m_read(4'h0, 3'h0));

        do_write("pre_shift M.high", 4'h1, 3'h0, 9'h03C);
        do_reconfig("wr_in_shift", 0, 20, 4'h1, 3'h0, 9'h0EE);
        do_read("wr_in_shift M.high", 4'h1, 3'h0, 9'h03C);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] t;
            logic [2:0] p;
            logic [8:0] d;
            t = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'({$urandom_range(0, 1), 1'b0, $urandom_range(0, 1)} & 3'b101);
            p = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'({$urandom_range(0, 1), 1'b0, $urandom_range(0, 1)} & 3'b101);
            d = 9'($urandom);
            if ($urandom_range(0, 1) == 1) do_write($sformatf("rnd%0d", i), t, p, d);
            else do_read($sformatf("rnd%0d", i), t, p, m_read(t, p));
        end
        do_reconfig("rc_random", 0, -1, 4'h0, 3'h0, 9'h0);
        do_read("pre_abort read C1.low", 4'h5, 3'h1, m_read(4'h5, 3'h1));

        begin
            int n_cu, n_busy;
            issue(0, 0, 1, 4'h0, 3'h0, 9'h0);
            for (int c = 1; c < 30; c++) tick();
            reset = 1;
            tick();
            reset = 0;
            m_reset();
            check("abort busy", 72'(busy), 72'(0));
            check("abort scanclkena", 72'(scanclkena), 72'(0));
            check("abort scandata", 72'(scandata), 72'(0));
            check("abort data_out", 72'(data_out), 72'(0));
            n_cu = 0; n_busy = 0;
            for (int c = 0; c < 100; c++) begin
                if (configupdate === 1'b1) n_cu++;
                if (busy === 1'b1) n_busy++;
                tick();
            end
            check("abort no configupdate", 72'(n_cu), 72'(0));
            check("abort stays idle", 72'(n_busy), 72'(0));
        end
        do_read("abort N.high", 4'h0, 3'h0, 9'h001);
        do_read("abort M.high", 4'h1, 3'h0, 9'h001);
        do_read("abort C0.bypass", 4'h4, 3'h4, 9'h000);
        do_read("abort C1.low", 4'h5, 3'h1, 9'h001);
        do_reconfig("rc_after_abort", 0, -1, 4'h0, 3'h0, 9'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
